hack_boot_sequencer: RTL and testbench

HACK_BOOT_SEQUENCER -- requirements
Module: hack_boot_sequencer

---
 rtl/hack_boot_sequencer.sv | 161 ++++++++++++++++
 tb/tb_hack_boot_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hack_boot_sequencer.sv
// Boot sequencer for the Hack SoC: loads ROM, holds the CPU in reset to settle,
// then runs, pauses or single-steps the CPU under button control.
module hack_boot_sequencer #(
    parameter int LOAD_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 8,
    parameter int STEP_CYCLES   = 1
) (
    input  logic        EXTERNAL_CLK,
    input  logic        reset,
    input  logic        loader_done,
    input  logic        pause_toggle,
    input  logic        step_req,
    input  logic        reload_req,
    input  logic        hold_reset,
    output logic        run_loader,
    output logic        hack_external_reset,
    output logic        cpu_clk_en,
    output logic [2:0]  state,
    output logic        load_error,
    output logic [15:0] load_cycles
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        PAUSED = 3'd4,
        STEP   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [15:0] LOAD_LAST   = 16'(LOAD_TIMEOUT - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] STEP_LAST   = 16'(STEP_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [15:0] counter_reg, counter_next;
    logic        load_error_reg, load_error_next;
    logic [15:0] load_cycles_reg, load_cycles_next;
    logic        run_loader_reg, run_loader_next;
    logic        force_reset_reg, force_reset_next;
    logic        hold_en_reg, hold_en_next;
    logic        clk_en_reg, clk_en_next;

    always_comb begin
        state_next       = state_reg;
        counter_next     = counter_reg;
        load_error_next  = load_error_reg;
        load_cycles_next = load_cycles_reg;
        case (state_reg)
            IDLE: begin
                counter_next = '0;
                state_next   = LOAD;
            end
            LOAD: begin
                // A completion on the timeout cycle still counts as success.
                if (loader_done) begin
                    load_cycles_next = counter_reg + 16'd1;
                    counter_next     = '0;
                    state_next       = SETTLE;
                end else if (counter_reg == LOAD_LAST) begin
                    load_error_next = 1'b1;
                    state_next      = ERROR;
                end else begin
                    counter_next = counter_reg + 16'd1;
                end
            end
            SETTLE: begin
                if (counter_reg == SETTLE_LAST) begin
                    counter_next = '0;
                    state_next   = RUN;
                end else begin
                    counter_next = counter_reg + 16'd1;
                end
            end
            RUN: begin
                if (reload_req)        state_next = IDLE;
                else if (pause_toggle) state_next = PAUSED;
            end
            PAUSED: begin
                if (reload_req)        state_next = IDLE;
                else if (pause_toggle) state_next = RUN;
                else if (step_req) begin
                    counter_next = '0;
                    state_next   = STEP;
                end
            end
            STEP: begin
                if (reload_req) begin
                    state_next = IDLE;
                end else if (counter_reg == STEP_LAST) begin
                    counter_next = '0;
                    state_next   = PAUSED;
                end else begin
                    counter_next = counter_reg + 16'd1;
                end
            end
            ERROR: begin
                if (reload_req) begin
                    load_error_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (reset) begin
            state_next       = IDLE;
            counter_next     = '0;
            load_error_next  = 1'b0;
            load_cycles_next = '0;
        end
    end

    // Output bits are decoded from the next state so they register alongside it.
    always_comb begin
        run_loader_next  = 1'b0;
        force_reset_next = 1'b1;
        hold_en_next     = 1'b0;
        clk_en_next      = 1'b0;
        case (state_next)
            LOAD:   run_loader_next = 1'b1;
            SETTLE: clk_en_next = 1'b1;
            RUN: begin
                force_reset_next = 1'b0;
                hold_en_next     = 1'b1;
                clk_en_next      = 1'b1;
            end
            PAUSED: begin
                force_reset_next = 1'b0;
                hold_en_next     = 1'b1;
            end
            STEP: begin
                force_reset_next = 1'b0;
                hold_en_next     = 1'b1;
                clk_en_next      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge EXTERNAL_CLK) begin
        state_reg       <= state_next;
        counter_reg     <= counter_next;
        load_error_reg  <= load_error_next;
        load_cycles_reg <= load_cycles_next;
        run_loader_reg  <= run_loader_next;
        force_reset_reg <= force_reset_next;
        hold_en_reg     <= hold_en_next;
        clk_en_reg      <= clk_en_next;
    end

    assign state               = state_reg;
    assign run_loader          = run_loader_reg;
    assign hack_external_reset = force_reset_reg | (hold_en_reg & hold_reset);
    assign cpu_clk_en          = clk_en_reg;
    assign load_error          = load_error_reg;
    assign load_cycles         = load_cycles_reg;

endmodule

// File: tb/tb_hack_boot_sequencer.sv
// Table-driven bench for hack_boot_sequencer with a queue scoreboard of
// expected outputs; hand sequences cover the SETTLE length and reset mid-STEP.
module tb_hack_boot_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        loader_done = 1'b0;
    logic        pause_toggle = 1'b0;
    logic        step_req = 1'b0;
    logic        reload_req = 1'b0;
    logic        hold_reset = 1'b0;
    logic        run_loader;
    logic        hack_external_reset;
    logic        cpu_clk_en;
    logic [2:0]  state;
    logic        load_error;
    logic [15:0] load_cycles;

    always #5 clk = ~clk;

    hack_boot_sequencer #(
        .LOAD_TIMEOUT (16),
        .SETTLE_CYCLES(8),
        .STEP_CYCLES  (2)
    ) dut (
        .EXTERNAL_CLK       (clk),
        .reset              (reset),
        .loader_done        (loader_done),
        .pause_toggle       (pause_toggle),
        .step_req           (step_req),
        .reload_req         (reload_req),
        .hold_reset         (hold_reset),
        .run_loader         (run_loader),
        .hack_external_reset(hack_external_reset),
        .cpu_clk_en         (cpu_clk_en),
        .state              (state),
        .load_error         (load_error),
        .load_cycles        (load_cycles)
    );

    typedef struct {
        logic [2:0]  state;
        logic        rl;
        logic        er;
        logic        ce;
        logic        le;
        logic [15:0] lc;
    } out_t;

    typedef struct {
        int unsigned cycles;
        logic rst, ld, pause, step, reload, hold;
        out_t exp;
    } vec_t;

    vec_t vq[$];
    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(int unsigned n, logic rst, logic ld, logic pt, logic sr,
                                logic rr, logic hr, logic [2:0] s, logic rl, logic er,
                                logic ce, logic le, logic [15:0] lc);
        vec_t v;
        v.cycles = n; v.rst = rst; v.ld = ld; v.pause = pt; v.step = sr;
        v.reload = rr; v.hold = hr;
        v.exp.state = s; v.exp.rl = rl; v.exp.er = er; v.exp.ce = ce;
        v.exp.le = le; v.exp.lc = lc;
        vq.push_back(v);
    endfunction

    function automatic out_t mk(logic [2:0] s, logic rl, logic er, logic ce, logic le,
                                logic [15:0] lc);
        out_t o;
        o.state = s; o.rl = rl; o.er = er; o.ce = ce; o.le = le; o.lc = lc;
        return o;
    endfunction

    task automatic drive(logic rst, logic ld, logic pt, logic sr, logic rr, logic hr);
        reset = rst; loader_done = ld; pause_toggle = pt;
        step_req = sr; reload_req = rr; hold_reset = hr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name);
        out_t e;
        e = exp_q.pop_front();
        checks++;
        if (state !== e.state || run_loader !== e.rl || hack_external_reset !== e.er ||
            cpu_clk_en !== e.ce || load_error !== e.le || load_cycles !== e.lc) begin
            errors++;
            $display("FAIL %s: got state=%0d rl=%b er=%b ce=%b le=%b lc=%0d, expected state=%0d rl=%b er=%b ce=%b le=%b lc=%0d",
                     name, state, run_loader, hack_external_reset, cpu_clk_en, load_error,
                     load_cycles, e.state, e.rl, e.er, e.ce, e.le, e.lc);
        end else begin
            $display("ok   %s: state=%0d rl=%b er=%b ce=%b le=%b lc=%0d",
                     name, state, run_loader, hack_external_reset, cpu_clk_en, load_error,
                     load_cycles);
        end
    endtask

    task automatic expect_bit(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    initial begin
        int settle_n;
        int settle_bad;

        //  n  rst ld pt sr rr hr | state rl er ce le lc
        add(2,  1, 0, 0, 0, 0, 0,  3'd0, 0, 1, 0, 0, 16'd0);  // in reset
        add(1,  0, 0, 0, 0, 0, 0,  3'd1, 1, 1, 0, 0, 16'd0);  // IDLE -> LOAD
        add(3,  0, 0, 0, 0, 0, 0,  3'd1, 1, 1, 0, 0, 16'd0);
        add(1,  0, 0, 0, 0, 0, 0,  3'd1, 1, 1, 0, 0, 16'd0);  // 5th LOAD cycle
        add(1,  0, 1, 0, 0, 0, 0,  3'd2, 0, 1, 1, 0, 16'd5);  // done -> SETTLE
        add(7,  0, 0, 0, 0, 0, 0,  3'd2, 0, 1, 1, 0, 16'd5);
        add(1,  0, 0, 0, 0, 0, 0,  3'd3, 0, 0, 1, 0, 16'd5);  // RUN
        add(1,  0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 1, 0, 16'd5);  // step ignored in RUN
        add(1,  0, 0, 1, 0, 0, 0,  3'd4, 0, 0, 0, 0, 16'd5);  // PAUSED
        add(1,  0, 0, 0, 1, 0, 0,  3'd5, 0, 0, 1, 0, 16'd5);  // STEP cycle 1
        add(1,  0, 0, 0, 1, 0, 0,  3'd5, 0, 0, 1, 0, 16'd5);  // STEP cycle 2
        add(1,  0, 0, 0, 0, 0, 0,  3'd4, 0, 0, 0, 0, 16'd5);  // back to PAUSED
        add(1,  0, 0, 1, 0, 0, 0,  3'd3, 0, 0, 1, 0, 16'd5);  // RUN
        add(1,  0, 0, 0, 0, 0, 1,  3'd3, 0, 1, 1, 0, 16'd5);  // hold_reset in RUN
        add(1,  0, 0, 1, 0, 1, 1,  3'd0, 0, 1, 0, 0, 16'd5);  // reload beats pause
        add(1,  0, 0, 0, 0, 0, 0,  3'd1, 1, 1, 0, 0, 16'd5);
        add(1,  0, 0, 0, 0, 1, 0,  3'd1, 1, 1, 0, 0, 16'd5);  // reload ignored in LOAD
        add(14, 0, 0, 0, 0, 0, 0,  3'd1, 1, 1, 0, 0, 16'd5);  // 16th LOAD cycle
        add(1,  0, 0, 0, 0, 0, 0,  3'd6, 0, 1, 0, 1, 16'd5);  // timeout -> ERROR
        add(1,  0, 0, 1, 0, 0, 0,  3'd6, 0, 1, 0, 1, 16'd5);
        add(1,  0, 0, 0, 0, 1, 0,  3'd0, 0, 1, 0, 0, 16'd5);  // reload clears error
        add(1,  0, 0, 0, 0, 0, 0,  3'd1, 1, 1, 0, 0, 16'd5);
        add(15, 0, 0, 0, 0, 0, 0,  3'd1, 1, 1, 0, 0, 16'd5);
        add(1,  0, 1, 0, 0, 0, 0,  3'd2, 0, 1, 1, 0, 16'd16); // done on timeout cycle
        add(8,  0, 0, 0, 0, 0, 0,  3'd3, 0, 0, 1, 0, 16'd16);
        add(1,  0, 0, 1, 0, 0, 0,  3'd4, 0, 0, 0, 0, 16'd16);
        add(1,  0, 0, 1, 0, 1, 0,  3'd0, 0, 1, 0, 0, 16'd16); // reload in PAUSED
        add(1,  0, 0, 0, 0, 0, 0,  3'd1, 1, 1, 0, 0, 16'd16);
        add(3,  0, 0, 0, 0, 0, 0,  3'd1, 1, 1, 0, 0, 16'd16);
        add(1,  1, 0, 0, 0, 0, 0,  3'd0, 0, 1, 0, 0, 16'd0);  // reset mid-LOAD
        add(1,  0, 0, 0, 0, 0, 0,  3'd1, 1, 1, 0, 0, 16'd0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].ld, vq[i].pause, vq[i].step, vq[i].reload, vq[i].hold);
            exp_q.push_back(vq[i].exp);
            for (int c = 0; c < int'(vq[i].cycles); c++) tick();
            check($sformatf("vec%0d", i));
        end

        // SETTLE length measured cycle by cycle, with a bounded loop.
        drive(0, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(3'd2, 0, 1, 1, 0, 16'd1));
        tick();
        check("settle_entry");
        drive(0, 0, 0, 0, 0, 0);
        settle_n = 0;
        settle_bad = 0;
        while (state == 3'd2 && settle_n < 50) begin
            if (hack_external_reset !== 1'b1 || cpu_clk_en !== 1'b1) settle_bad++;
            settle_n++;
            tick();
        end
        expect_bit("settle_cycles", settle_n, 8);
        expect_bit("settle_outputs_bad", settle_bad, 0);
        exp_q.push_back(mk(3'd3, 0, 0, 1, 0, 16'd1));
        check("settle_to_run");

        // Reset asserted mid-STEP.
        drive(0, 0, 1, 0, 0, 0);
        exp_q.push_back(mk(3'd4, 0, 0, 0, 0, 16'd1));
        tick();
        check("pause_again");
        drive(0, 0, 0, 1, 0, 0);
        exp_q.push_back(mk(3'd5, 0, 0, 1, 0, 16'd1));
        tick();
        check("step_again");
        drive(1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(3'd0, 0, 1, 0, 0, 16'd0));
        tick();
        check("reset_mid_step");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
